// File: rtl/y86_instr_encoder.sv
// y86_instr_encoder: serialises decoded Y86-64 instruction fields into the
// byte-addressed instruction memory, one byte per cycle, keeping a write
// pointer that mirrors the fetch stage's valP.
module y86_instr_encoder #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic [63:0] load_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  icode_i,
  input  logic [3:0]  ifun_i,
  input  logic [3:0]  rA_i,
  input  logic [3:0]  rB_i,
  input  logic [63:0] valC_i,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic [63:0] ptr_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned AW = 64;
  localparam int unsigned BW = 8;
  localparam int unsigned IW = 80;
  localparam int unsigned CW = 4;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   len_q;
  logic [IW-1:0]   instr_q;

  logic [CW-1:0]   len_c;
  logic [IW-1:0]   instr_c;
  logic            accept_c;
  logic            bad_c;
  logic [CW-1:0]   next_idx_c;
  logic [BW-1:0]   next_byte_c;

  // Instruction length from icode; zero marks an invalid icode.
  always_comb begin
    len_c = 4'd0;
    case (icode_i)
      4'h0, 4'h1, 4'h9:        len_c = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  len_c = 4'd2;
      4'h7, 4'h8:              len_c = 4'd9;
      4'h3, 4'h4, 4'h5:        len_c = 4'd10;
      default:                 len_c = 4'd0;
    endcase
  end

  // Full byte image of the instruction, byte k at bits [8k+7:8k].
  always_comb begin
    instr_c = '0;
    if (len_c == 4'd2 || len_c == 4'd10)
      instr_c = {valC_i, rA_i, rB_i, icode_i, ifun_i};
    else
      instr_c = {8'h00, valC_i, icode_i, ifun_i};
  end

  assign in_ready_o  = (state_q == IDLE) && !load_i;
  assign accept_c    = in_valid_i && in_ready_o;
  // 65-bit sum so a pointer near 2^64 cannot wrap past the bound check.
  assign bad_c       = (len_c == 4'd0) ||
                       (({1'b0, ptr_o} + 65'(len_c)) > 65'(MEM_SIZE));
  assign next_idx_c  = cnt_q + 4'd1;
  assign next_byte_c = BW'(instr_q >> {next_idx_c, 3'b000});

  // Control FSM, write pointer and registered memory-port outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      instr_q     <= '0;
      ptr_o       <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_i) begin
            ptr_o <= load_addr_i;
          end else if (accept_c) begin
            if (bad_c) begin
              err_o <= 1'b1;
            end else begin
              state_q     <= EMIT;
              cnt_q       <= '0;
              len_q       <= len_c;
              instr_q     <= instr_c;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= ptr_o;
              mem_wdata_o <= instr_c[BW-1:0];
              done_o      <= (len_c == 4'd1);
            end
          end
        end
        EMIT: begin
          if (cnt_q == len_q - 4'd1) begin
            state_q <= IDLE;
            ptr_o   <= ptr_o + AW'(len_q);
          end else begin
            cnt_q       <= next_idx_c;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= ptr_o + AW'(next_idx_c);
            mem_wdata_o <= next_byte_c;
            done_o      <= (next_idx_c == len_q - 4'd1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// tb_y86_instr_encoder: directed plus randomized bench for the Y86-64
// instruction encoder, with a byte-list reference model and a fetch model.
module tb_y86_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [63:0] load_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc;
  logic        we;
  logic [63:0] addr;
  logic [7:0]  wdata;
  logic [63:0] ptr;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_ptr = 64'd0;
  logic [7:0]  tbmem [0:1023];

  // Instruction length per icode straight from the ISA table; 0 = invalid.
  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};

  // Round-trip record of the encoder inputs and where each one landed.
  logic [3:0]  rt_ic [6];
  logic [3:0]  rt_fn [6];
  logic [3:0]  rt_ra [6];
  logic [3:0]  rt_rb [6];
  logic [63:0] rt_vc [6];
  logic [63:0] rt_pc [7];

  y86_instr_encoder #(.MEM_SIZE(1024)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .load_i(load), .load_addr_i(load_addr),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .icode_i(icode),
    .ifun_i(ifun), .rA_i(ra), .rB_i(rb), .valC_i(valc), .mem_we_o(we),
    .mem_addr_o(addr), .mem_wdata_o(wdata), .ptr_o(ptr), .done_o(done),
    .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_ptr", ptr, 64'd0);
    check("rst_we", {63'd0, we}, 64'd0);
    check("rst_addr", addr, 64'd0);
    check("rst_wdata", {56'd0, wdata}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    rst_n = 1'b1;
    #1 check("rst_rdy", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    exp_ptr = 64'd0;
  endtask

  // Load the pointer, optionally with a competing instruction offered.
  task automatic load_ptr(input logic [63:0] a, input bit with_valid);
    load = 1'b1; load_addr = a;
    if (with_valid) begin
      in_valid = 1'b1; icode = 4'h0; ifun = 4'h0;
    end
    #1 check("load_rdy", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    load = 1'b0; in_valid = 1'b0;
    check("load_ptr", ptr, a);
    check("load_we", {63'd0, we}, 64'd0);
    check("load_err", {63'd0, err}, 64'd0);
    exp_ptr = a;
    @(negedge clk);
    check("load_no_write", {63'd0, we}, 64'd0);
    check("load_ptr_hold", ptr, a);
  endtask

  // Offer one instruction and check the full byte stream against the model.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [63:0] vc);
    logic [7:0] q[$];
    int len;
    logic [64:0] endp;
    len = len_tab[ic];
    q.push_back({ic, fn});
    if (len == 2 || len == 10) q.push_back({a, b});
    if (len >= 9) for (int i = 0; i < 8; i++) q.push_back(vc[8*i +: 8]);
    endp = {1'b0, exp_ptr} + 65'(len);
    check("send_rdy", {63'd0, in_ready}, 64'd1);
    icode = ic; ifun = fn; ra = a; rb = b; valc = vc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (len == 0 || endp > 65'd1024) begin
      check("err_pulse", {63'd0, err}, 64'd1);
      check("err_no_we", {63'd0, we}, 64'd0);
      check("err_no_done", {63'd0, done}, 64'd0);
      @(negedge clk);
      check("err_clear", {63'd0, err}, 64'd0);
      check("err_ptr", ptr, exp_ptr);
      check("err_rdy", {63'd0, in_ready}, 64'd1);
    end else begin
      for (int k = 0; k < len; k++) begin
        check("wr_we", {63'd0, we}, 64'd1);
        check("wr_addr", addr, exp_ptr + 64'(k));
        check("wr_data", {56'd0, wdata}, {56'd0, q[k]});
        check("wr_done", {63'd0, done}, (k == len - 1) ? 64'd1 : 64'd0);
        check("wr_err", {63'd0, err}, 64'd0);
        check("wr_rdy", {63'd0, in_ready}, 64'd0);
        check("wr_ptr", ptr, exp_ptr);
        if (we && addr < 64'd1024) tbmem[addr[9:0]] = wdata;
        @(negedge clk);
      end
      exp_ptr = exp_ptr + 64'(len);
      check("end_we", {63'd0, we}, 64'd0);
      check("end_done", {63'd0, done}, 64'd0);
      check("end_ptr", ptr, exp_ptr);
      check("end_rdy", {63'd0, in_ready}, 64'd1);
    end
  endtask

  // Fetch-stage model: decode one instruction from tbmem and compare.
  task automatic fetch_check(input int idx);
    logic [63:0] pc, vp, v;
    logic [3:0]  fic, ffn;
    int len, off;
    pc  = rt_pc[idx];
    fic = tbmem[pc[9:0]][7:4];
    ffn = tbmem[pc[9:0]][3:0];
    len = len_tab[fic];
    check("rt_icode", {60'd0, fic}, {60'd0, rt_ic[idx]});
    check("rt_ifun", {60'd0, ffn}, {60'd0, rt_fn[idx]});
    off = 1;
    if (len == 2 || len == 10) begin
      check("rt_ra", {60'd0, tbmem[pc[9:0] + 10'd1][7:4]}, {60'd0, rt_ra[idx]});
      check("rt_rb", {60'd0, tbmem[pc[9:0] + 10'd1][3:0]}, {60'd0, rt_rb[idx]});
      off = 2;
    end
    if (len >= 9) begin
      v = '0;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = tbmem[pc[9:0] + 10'(off + i)];
      check("rt_valc", v, rt_vc[idx]);
    end
    vp = pc + 64'(len);
    check("rt_valp", vp, rt_pc[idx + 1]);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; load_addr = '0; in_valid = 1'b0;
    icode = '0; ifun = '0; ra = '0; rb = '0; valc = '0;
    for (int i = 0; i < 1024; i++) tbmem[i] = 8'hAA;
    @(negedge clk);
    do_reset();

    // nop, halt
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'd0);
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
    check("ptr_after_halt", ptr, 64'd2);

    // irmovq at 4
    load_ptr(64'd4, 1'b0);
    send(4'h3, 4'h0, 4'hF, 4'h5, 64'h0123456789ABCDEF);
    check("ptr_irmovq", ptr, 64'd14);

    // call at 24, then OPq back-to-back
    load_ptr(64'd24, 1'b0);
    send(4'h8, 4'h0, 4'hF, 4'hF, 64'h100);
    send(4'h6, 4'h1, 4'h5, 4'h6, 64'd0);
    check("ptr_opq", ptr, 64'd35);

    // invalid icode and overflow boundaries
    send(4'hE, 4'h0, 4'h1, 4'h2, 64'd0);
    load_ptr(64'd1020, 1'b0);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h55);
    load_ptr(64'd1022, 1'b0);
    send(4'h2, 4'h0, 4'h3, 4'h4, 64'd0);
    check("ptr_top", ptr, 64'd1024);
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'd0);
    load_ptr(64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'd0);

    // reset during the 4th write cycle of an irmovq
    do_reset();
    icode = 4'h3; ifun = 4'h0; ra = 4'hF; rb = 4'h1;
    valc = 64'h1122334455667788; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("abort_we", {63'd0, we}, 64'd1);
      @(negedge clk);
    end
    check("abort_4th_we", {63'd0, we}, 64'd1);
    check("abort_4th_addr", addr, 64'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_no_we", {63'd0, we}, 64'd0);
    check("abort_ptr", ptr, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    #1 check("abort_rdy", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    check("abort_still_no_we", {63'd0, we}, 64'd0);
    exp_ptr = 64'd0;

    // load wins over a simultaneous instruction
    load_ptr(64'd50, 1'b1);

    // round trip through the fetch model
    do_reset();
    for (int i = 0; i < 1024; i++) tbmem[i] = 8'hAA;
    rt_ic = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
    rt_fn = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    rt_ra = '{4'hF, 4'hF, 4'h3, 4'hF, 4'h1, 4'h5};
    rt_rb = '{4'hF, 4'hF, 4'h4, 4'h2, 4'h2, 4'h6};
    rt_vc = '{64'd0, 64'd0, 64'd0, 64'hDEADBEEFCAFEF00D, 64'h100, 64'd0};
    for (int i = 0; i < 6; i++) begin
      rt_pc[i] = exp_ptr;
      send(rt_ic[i], rt_fn[i], rt_ra[i], rt_rb[i], rt_vc[i]);
    end
    rt_pc[6] = exp_ptr;
    check("rt_pc2", rt_pc[2], 64'd2);
    check("rt_pc4", rt_pc[4], 64'd14);
    check("rt_pc5", rt_pc[5], 64'd24);
    check("rt_final_ptr", ptr, 64'd26);
    for (int i = 0; i < 6; i++) fetch_check(i);

    // randomized instructions and pointer loads
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0)
          load_ptr(64'($urandom_range(1010, 1023)), $urandom_range(0, 1) == 1);
        else
          load_ptr(64'($urandom_range(0, 1000)), 1'b0);
      end
      send(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
           {32'($urandom), 32'($urandom)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_instr_encoder.md
Name: y86_instr_encoder

Overview:
- Inverse of the Y86-64 fetch stage: accepts decoded instruction fields (icode, ifun, rA, rB, valC) and serialises them into the byte-addressed instruction memory in standard Y86-64 encoding, one byte per cycle.
- valC is written little-endian.
- Sits between the program loader / test harness and the instruction-memory write port, so that a fetch stage can later decode the same program.
- Keeps its own write pointer, which advances by each instruction's length. This pointer mirrors valP in the fetch stage.

Parameters:
- MEM_SIZE, 1024, instruction-memory size in bytes. Legal addresses are 0..MEM_SIZE-1.

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  synchronous reset, active-low
- load_i  input  1  load write pointer from load_addr_i (honoured in IDLE only)
- load_addr_i  input  64  new write-pointer value
- in_valid_i  input  1  instruction fields valid
- in_ready_o  output  1  encoder can accept an instruction
- icode_i  input  4  instruction code
- ifun_i  input  4  function code
- rA_i  input  4  register A (0xF = none)
- rB_i  input  4  register B (0xF = none)
- valC_i  input  64  constant / displacement / destination
- mem_we_o  output  1  instruction-memory byte write enable
- mem_addr_o  output  64  byte write address
- mem_wdata_o  output  8  byte write data
- ptr_o  output  64  current write pointer (address of next instruction)
- done_o  output  1  one-cycle pulse with the last byte of an instruction
- err_o  output  1  one-cycle pulse: instruction rejected

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - state IDLE, ptr_o=0.
  - mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, done_o=0, err_o=0.
  - A reset during EMIT aborts the instruction: no write occurs on the following cycle, and the partial bytes already written stay in memory.
- Length by icode:
  - 1 byte: 0 (nop), 1 (halt), 9 (ret).
  - 2 bytes: 2 (rrmovq/cmovXX), 6 (OPq), A (pushq), B (popq).
  - 9 bytes: 7 (jXX), 8 (call).
  - 10 bytes: 3 (irmovq), 4 (rmmovq), 5 (mrmovq).
  - icode C..F is invalid.
- Byte layout:
  - Byte 0 = {icode,ifun}.
  - For 2- and 10-byte forms, byte 1 = {rA,rB}.
  - Then valC bytes 0..7, LSB first. 9-byte forms have no register byte.
  - rA/rB/ifun are written as given and are not checked.
- in_ready_o = (state==IDLE) && !load_i. This is combinational.
- Pointer load: load_i high in IDLE sets ptr_o=load_addr_i on the next cycle. load_i is ignored in EMIT. If load_i and in_valid_i are high in the same cycle, the load wins and no instruction is accepted.
- Accept: in_valid_i && in_ready_o at edge T latches all fields and the length.
  - Invalid icode: err_o=1 in cycle T+1, no writes, ptr unchanged, stay IDLE.
  - Overflow (ptr_o+len > MEM_SIZE, computed in 65 bits so there is no wrap): err_o=1 in T+1, no writes, ptr unchanged, stay IDLE.
  - Otherwise: state EMIT. mem_we_o=1 in cycles T+1..T+len, with mem_addr_o=ptr+k and mem_wdata_o=byte k.
- Last write cycle (T+len):
  - done_o=1.
  - ptr_o updates to ptr+len from T+len+1.
  - State returns to IDLE, so in_ready_o is high from T+len+1.
- Throughput: back-to-back instructions need len+1 cycles each.
- Registered outputs: mem_addr_o/mem_wdata_o keep their last value when mem_we_o=0. err_o and done_o are never high together.
- States:
  - IDLE: on accept go to EMIT, or stay in IDLE on error.
  - EMIT: a byte counter counts from 0 to len-1; go to IDLE when the counter reaches len-1.

Test Plan:
- Reset, nop (icode 0, ifun 0) -> one write addr 0 data 0x00, done_o with it, ptr_o=1 the next cycle; then halt -> addr 1 data 0x10, ptr_o=2.
- load 4, irmovq (icode 3, ifun 0, rA F, rB 5, valC 0x0123456789ABCDEF) -> 10 consecutive writes to addrs 4..13 of data 30 F5 EF CD AB 89 67 45 23 01; ptr_o=14; in_ready_o low for exactly 10 cycles after accept.
- call (icode 8, valC 0x100) at ptr 24 -> 9 writes 80 00 01 00 00 00 00 00 00 to addrs 24..32; ptr_o=33. Then OPq (icode 6, ifun 1, rA 5, rB 6) -> writes 61 56, ptr_o=35.
- Invalid and overflow cases:
  - icode E -> err_o pulse, no mem_we_o, ptr unchanged.
  - load 1020, then rmmovq (10 bytes) -> err_o, no writes.
  - load 1022, then rrmovq -> writes at 1022 and 1023, ptr_o=1024.
- Reset in the 4th write cycle of an irmovq -> no writes afterwards, ptr_o=0, in_ready_o=1 once reset is released. Simultaneous load_i and in_valid_i in IDLE -> load is taken, no instruction is accepted.
- Round-trip: encode the sequence nop, halt, rrmovq 3,4, irmovq, rmmovq 1,2,0x100, OPq 5,6 into a memory model, then drive the fetch stage at PCs 0, 1, 2, 4, 14 and 24 -> decoded fields and valP match the encoder inputs and ptr_o progression.
